// File: rtl/vcve2_pkg.sv
// vcve2 shared types: SEW encodings, vector op codes and sequencer states.
// Imported by the vector sequencer and its packed SIMD ALU.
package vcve2_pkg;

  localparam logic [2:0] VSEW_8  = 3'b000;
  localparam logic [2:0] VSEW_16 = 3'b001;
  localparam logic [2:0] VSEW_32 = 3'b010;

  typedef enum logic [1:0] {
    VOP_ADD,
    VOP_SUB,
    VOP_MAC,
    VOP_REDSUM
  } vec_op_e;

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_RUN,
    VS_DRAIN
  } vec_state_e;

  // Element width in bits for a legal 2-bit SEW code.
  function automatic int unsigned sew_bits(logic [1:0] code);
    return 32'd8 << code;
  endfunction

endpackage

// File: rtl/vcve2_vec_simd_alu.sv
// Packed SIMD ADD/SUB/MAC over one DATA_W beat, carries cut at SEW edges.
// Ports: op_i, sew_i (2-bit SEW code), a_i/b_i/d_i operands,
// mask_i (per-byte active mask, inactive bytes keep d_i), res_o result.
module vcve2_vec_simd_alu
  import vcve2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  vec_op_e             op_i,
  input  logic [1:0]          sew_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [DATA_W-1:0]   d_i,
  input  logic [DATA_W/8-1:0] mask_i,
  output logic [DATA_W-1:0]   res_o
);

  localparam int NBY = DATA_W / 8;

  logic [DATA_W-1:0] addsub;
  logic [DATA_W-1:0] mac8;
  logic [DATA_W-1:0] mac16;
  logic [DATA_W-1:0] mac32;
  logic [DATA_W-1:0] raw;
  logic [8:0]        s;
  logic [7:0]        bb;
  logic              c;
  logic              head;
  logic              sub;

  // Byte-serial carry chain; an element's first byte takes the
  // fresh carry-in (1 for subtract) instead of the previous carry.
  always_comb begin
    addsub = '0;
    s      = '0;
    bb     = '0;
    c      = 1'b0;
    head   = 1'b0;
    sub    = (op_i == VOP_SUB);
    for (int i = 0; i < NBY; i++) begin
      head = (sew_i == 2'd0) ||
             ((sew_i == 2'd1) && (i % 2 == 0)) ||
             (i % 4 == 0);
      bb = sub ? ~b_i[8*i +: 8] : b_i[8*i +: 8];
      s  = {1'b0, a_i[8*i +: 8]} + {1'b0, bb} +
           {8'd0, head ? sub : c};
      addsub[8*i +: 8] = s[7:0];
      c = s[8];
    end
  end

  always_comb begin
    mac8  = '0;
    mac16 = '0;
    mac32 = '0;
    for (int i = 0; i < NBY; i++) begin
      mac8[8*i +: 8] = d_i[8*i +: 8] +
                       a_i[8*i +: 8] * b_i[8*i +: 8];
    end
    for (int i = 0; i < NBY / 2; i++) begin
      mac16[16*i +: 16] = d_i[16*i +: 16] +
                          a_i[16*i +: 16] * b_i[16*i +: 16];
    end
    for (int i = 0; i < NBY / 4; i++) begin
      mac32[32*i +: 32] = d_i[32*i +: 32] +
                          a_i[32*i +: 32] * b_i[32*i +: 32];
    end
  end

  always_comb begin
    raw = addsub;
    if (op_i == VOP_MAC) begin
      case (sew_i)
        2'd0:    raw = mac8;
        2'd1:    raw = mac16;
        default: raw = mac32;
      endcase
    end
  end

  // Tail-undisturbed merge.
  always_comb begin
    res_o = d_i;
    for (int i = 0; i < NBY; i++) begin
      if (mask_i[i]) res_o[8*i +: 8] = raw[8*i +: 8];
    end
  end

endmodule

// File: rtl/vcve2_vec_seq.sv
// Multi-beat vector element sequencer: walks vd beat by beat, packed SIMD.
// Ports: clk_i/rst_ni (sync, active-low), start_i/ready_o accept,
// op_i/vsew_i/vl_i instruction, rd_* beat read port, wr_* beat write,
// red_result_o reduction sum, done_o/error_o completion.
// Macro VCVE2_VEC_REDSUM_EN enables VOP_REDSUM; otherwise it is illegal.
module vcve2_vec_seq
  import vcve2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int VLEN   = 128,
  localparam int NB    = VLEN / DATA_W,
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1,
  localparam int VLW   = $clog2(VLEN / 8) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              ready_o,
  input  vec_op_e           op_i,
  input  logic [2:0]        vsew_i,
  input  logic [VLW-1:0]    vl_i,
  output logic              rd_req_o,
  output logic [BW-1:0]     rd_idx_o,
  input  logic              rd_gnt_i,
  input  logic [DATA_W-1:0] rd_a_i,
  input  logic [DATA_W-1:0] rd_b_i,
  input  logic [DATA_W-1:0] rd_d_i,
  output logic              wr_en_o,
  output logic [BW-1:0]     wr_idx_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [DATA_W-1:0] red_result_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int NBY = DATA_W / 8;
  localparam int BYL = $clog2(NBY);

  vec_state_e        state_q, state_d;
  vec_op_e           op_q;
  logic [1:0]        sew_q;
  logic [VLW-1:0]    nbytes_q;
  logic              err_q;
  logic [BW-1:0]     cnt_q;
  logic              wr_en_q;
  logic [BW-1:0]     wr_idx_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              accept;
  logic              legal;
  logic              last;
  logic [VLW-1:0]    vlmax;
  logic [VLW-1:0]    vl_c;
  logic [VLW-1:0]    nbytes_c;
  logic [BW-1:0]     last_beat;
  logic [NBY-1:0]    mask;
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    legal = (vsew_i <= VSEW_32) &&
            (sew_bits(vsew_i[1:0]) <= DATA_W);
`ifndef VCVE2_VEC_REDSUM_EN
    if (op_i == VOP_REDSUM) legal = 1'b0;
`endif
  end

  // vl is clamped to VLMAX and tracked as an active byte count,
  // so the tail mask and beat count are SEW-independent.
  assign vlmax    = VLW'((VLEN / 8) >> vsew_i[1:0]);
  assign vl_c     = (vl_i > vlmax) ? vlmax : vl_i;
  assign nbytes_c = vl_c << vsew_i[1:0];

  assign last_beat = BW'((nbytes_q - 1'b1) >> BYL);
  assign last      = (cnt_q == last_beat);
  assign accept    = start_i & ready_o;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NBY; i++) begin
      mask[i] = (int'(cnt_q) * NBY + i) < int'(nbytes_q);
    end
  end

  vcve2_vec_simd_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i   (op_q),
    .sew_i  (sew_q),
    .a_i    (rd_a_i),
    .b_i    (rd_b_i),
    .d_i    (rd_d_i),
    .mask_i (mask),
    .res_o  (alu_res)
  );

`ifdef VCVE2_VEC_REDSUM_EN
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] d0_q;
  logic [DATA_W-1:0] red_next;
  logic [DATA_W-1:0] red_wdata;
  logic [DATA_W-1:0] el0_mask;
  logic [7:0]        s8;
  logic [15:0]       s16;
  logic [31:0]       s32;

  // Beat 0 seeds the sum with vs1[0]; later beats continue acc_q.
  always_comb begin
    s8  = (cnt_q == '0) ? rd_a_i[7:0]  : acc_q[7:0];
    s16 = (cnt_q == '0) ? rd_a_i[15:0] : acc_q[15:0];
    s32 = (cnt_q == '0) ? rd_a_i[31:0] : acc_q[31:0];
    for (int i = 0; i < NBY; i++) begin
      if (mask[i]) s8 = s8 + rd_b_i[8*i +: 8];
    end
    for (int i = 0; i < NBY / 2; i++) begin
      if (mask[2*i]) s16 = s16 + rd_b_i[16*i +: 16];
    end
    for (int i = 0; i < NBY / 4; i++) begin
      if (mask[4*i]) s32 = s32 + rd_b_i[32*i +: 32];
    end
    case (sew_q)
      2'd0: begin
        red_next = DATA_W'(s8);
        el0_mask = DATA_W'(8'hff);
      end
      2'd1: begin
        red_next = DATA_W'(s16);
        el0_mask = DATA_W'(16'hffff);
      end
      default: begin
        red_next = DATA_W'(s32);
        el0_mask = DATA_W'(32'hffff_ffff);
      end
    endcase
    red_wdata = (((cnt_q == '0) ? rd_d_i : d0_q) & ~el0_mask) |
                red_next;
  end

  assign red_result_o = acc_q;
`else
  assign red_result_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= VS_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    rd_req_o = 1'b0;
    done_o   = 1'b0;
    error_o  = 1'b0;
    unique case (state_q)
      VS_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_d = (legal && (nbytes_c != '0)) ? VS_RUN : VS_DRAIN;
        end
      end
      VS_RUN: begin
        rd_req_o = 1'b1;
        if (rd_gnt_i && last) state_d = VS_DRAIN;
      end
      VS_DRAIN: begin
        done_o  = 1'b1;
        error_o = err_q;
        state_d = VS_IDLE;
      end
      default: state_d = VS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q      <= VOP_ADD;
      sew_q     <= '0;
      nbytes_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
`ifdef VCVE2_VEC_REDSUM_EN
      acc_q     <= '0;
      d0_q      <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (accept) begin
        op_q     <= op_i;
        sew_q    <= vsew_i[1:0];
        nbytes_q <= legal ? nbytes_c : '0;
        err_q    <= !legal;
        cnt_q    <= '0;
`ifdef VCVE2_VEC_REDSUM_EN
        acc_q    <= '0;
`endif
      end
      if ((state_q == VS_RUN) && rd_gnt_i) begin
        cnt_q <= cnt_q + 1'b1;
`ifdef VCVE2_VEC_REDSUM_EN
        if (op_q == VOP_REDSUM) begin
          acc_q <= red_next;
          if (cnt_q == '0) d0_q <= rd_d_i;
          if (last) begin
            wr_en_q   <= 1'b1;
            wr_idx_q  <= '0;
            wr_data_q <= red_wdata;
          end
        end else
`endif
        begin
          wr_en_q   <= 1'b1;
          wr_idx_q  <= cnt_q;
          wr_data_q <= alu_res;
        end
      end
    end
  end

  assign rd_idx_o  = cnt_q;
  assign wr_en_o   = wr_en_q;
  assign wr_idx_o  = wr_idx_q;
  assign wr_data_o = wr_data_q;

endmodule
